// File: rtl/hack_alu_mc_pkg.sv
// Shared definitions for the registered Hack ALU: FSM state encoding and the
// bit positions of the six Hack control bits when they travel as one vector.
package hack_alu_mc_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam int CTL_W  = 6;
  localparam int CTL_ZX = 5;
  localparam int CTL_NX = 4;
  localparam int CTL_ZY = 3;
  localparam int CTL_NY = 2;
  localparam int CTL_F  = 1;
  localparam int CTL_NO = 0;

endpackage

// File: rtl/hack_alu_mc_if.sv
// Request/result bundle for hack_alu_mc: valid/ready on both sides, operands,
// Hack control bits and the registered result with its zr/ng flags.
interface hack_alu_mc_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             zx, nx, zy, ny, f, no;
  logic             mul;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;

  modport master (
    output in_valid, x, y, zx, nx, zy, ny, f, no, mul, out_ready,
    input  in_ready, out_valid, out, zr, ng
  );

  modport slave (
    input  in_valid, x, y, zx, nx, zy, ny, f, no, mul, out_ready,
    output in_ready, out_valid, out, zr, ng
  );
endinterface

// File: rtl/hack_alu_mc_alu_core.sv
// Combinational Hack ALU: zero/negate preprocessing of both operands, then
// add-or-and and optional output negation. Preprocessed operands are exported.
module alu_core
  import hack_alu_mc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [CTL_W-1:0] ctl,
  output logic [WIDTH-1:0] xp,
  output logic [WIDTH-1:0] yp,
  output logic [WIDTH-1:0] res
);

  logic [WIDTH-1:0] xz;
  logic [WIDTH-1:0] yz;
  logic [WIDTH-1:0] r;

  always_comb begin
    xz  = ctl[CTL_ZX] ? '0 : x;
    yz  = ctl[CTL_ZY] ? '0 : y;
    xp  = ctl[CTL_NX] ? ~xz : xz;
    yp  = ctl[CTL_NY] ? ~yz : yz;
    r   = ctl[CTL_F] ? (xp + yp) : (xp & yp);
    res = ctl[CTL_NO] ? ~r : r;
  end

endmodule

// File: rtl/hack_alu_mc.sv
// Registered Hack ALU with shift-add multiply: ALU ops return the cycle after
// accept, multiplies after WIDTH+1 edges; a stalled result blocks new requests.
module hack_alu_mc
  import hack_alu_mc_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic         clk,
  input logic         reset,
  hack_alu_mc_if.slave bus
);

  state_t           state;
  state_t           state_nxt;
  logic [CTL_W-1:0] ctl;
  logic [WIDTH-1:0] xp;
  logic [WIDTH-1:0] yp;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mul_res;
  logic [CNT_W-1:0] cnt;
  logic             no_q;
  logic [WIDTH-1:0] res_q;
  logic             zr_q;
  logic             ng_q;
  logic             out_valid_q;
  logic             in_ready;
  logic             accept;
  logic             mul_done;

  always_comb begin
    ctl         = '0;
    ctl[CTL_ZX] = bus.zx;
    ctl[CTL_NX] = bus.nx;
    ctl[CTL_ZY] = bus.zy;
    ctl[CTL_NY] = bus.ny;
    ctl[CTL_F]  = bus.f;
    ctl[CTL_NO] = bus.no;
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .x   (bus.x),
    .y   (bus.y),
    .ctl (ctl),
    .xp  (xp),
    .yp  (yp),
    .res (alu_res)
  );

  assign in_ready = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign mul_done = (state == ST_MUL) && (cnt == CNT_W'(WIDTH));
  assign mul_res  = no_q ? ~acc : acc;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && bus.mul) state_nxt = ST_MUL;
      ST_MUL:  if (mul_done)          state_nxt = ST_IDLE;
      default:                        state_nxt = ST_IDLE;
    endcase
  end

  // Entering MUL always vacates the output slot, so mul_done never overwrites a pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
      no_q        <= 1'b0;
      res_q       <= '0;
      zr_q        <= 1'b1;
      ng_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (bus.out_ready) out_valid_q <= 1'b0;
      if (accept) begin
        if (bus.mul) begin
          mcand  <= xp;
          mplier <= yp;
          acc    <= '0;
          cnt    <= '0;
          no_q   <= bus.no;
        end else begin
          res_q       <= alu_res;
          zr_q        <= (alu_res == '0);
          ng_q        <= alu_res[WIDTH-1];
          out_valid_q <= 1'b1;
        end
      end else if (state == ST_MUL) begin
        if (mul_done) begin
          res_q       <= mul_res;
          zr_q        <= (mul_res == '0);
          ng_q        <= mul_res[WIDTH-1];
          out_valid_q <= 1'b1;
        end else begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = res_q;
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;

endmodule
